// File: rtl/dsi_lane_hs_sequencer.sv
// Per-lane D-PHY transmit sequencer. Walks one HS burst
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11
// and paces the upstream bridge with data_rqst.
//
// Line outputs (lp_p, lp_n, hs_en, hs_data) are registered from the current
// state, so the line is a one-byte-clock delayed image of the state sequence.
// This keeps protocol bytes and payload bytes in one gap-free stream: the sync
// byte leaves during the first DATA cycle and each payload byte leaves the
// cycle after it is consumed.
//
// Handshake with the bridge: data_rqst is a ready. In DATA, inp_data (the
// valid side, always present while a burst is open) is consumed on every
// clock edge where data_rqst is high. In IDLE, data_rqst high means a
// start_rqst is accepted on this edge; start_rqst outside IDLE is ignored.
module dsi_lane_hs_sequencer #(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_lp,
    input  logic       start_rqst,
    input  logic       fin_rqst,
    input  logic [7:0] inp_data,
    output logic       data_rqst,
    output logic       hs_en,
    output logic [7:0] hs_data,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       err_lp_rqst
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LPX   = 3'd1;
    localparam logic [2:0] S_PREP  = 3'd2;
    localparam logic [2:0] S_ZERO  = 3'd3;
    localparam logic [2:0] S_SYNC  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_TRAIL = 3'd6;
    localparam logic [2:0] S_EXIT  = 3'd7;

    // 0xB8 bit-reversed, because the serializer shifts hs_data[7] out first
    localparam logic [7:0] SYNC_BYTE = 8'h1D;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic       fin_seen;
    logic       last_bit;
    logic       start_hs;

    // Timer preload for a timed state: param - 1, so the state lasts param cycles
    function automatic logic [7:0] timer_load(input logic [2:0] s);
        case (s)
            S_LPX:   timer_load = 8'(T_LPX - 1);
            S_PREP:  timer_load = 8'(T_HS_PREPARE - 1);
            S_ZERO:  timer_load = 8'(T_HS_ZERO - 1);
            S_TRAIL: timer_load = 8'(T_HS_TRAIL - 1);
            S_EXIT:  timer_load = 8'(T_HS_EXIT - 1);
            default: timer_load = 8'd0;
        endcase
    endfunction

    assign start_hs  = (state == S_IDLE) && start_rqst && !mode_lp;
    assign data_rqst = (state == S_IDLE) || (state == S_DATA);

    // Next-state decode: timed states leave when the timer reads 0
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_hs)              state_nxt = S_LPX;
            S_LPX:   if (timer == 8'd0)         state_nxt = S_PREP;
            S_PREP:  if (timer == 8'd0)         state_nxt = S_ZERO;
            S_ZERO:  if (timer == 8'd0)         state_nxt = S_SYNC;
            S_SYNC:                             state_nxt = S_DATA;
            S_DATA:  if (fin_rqst || fin_seen)  state_nxt = S_TRAIL;
            S_TRAIL: if (timer == 8'd0)         state_nxt = S_EXIT;
            S_EXIT:  if (timer == 8'd0)         state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // Timer reloads on every state change, otherwise counts down to 0 and holds
    always_comb begin
        timer_nxt = timer;
        if (state_nxt != state) begin
            timer_nxt = timer_load(state_nxt);
        end else if (timer != 8'd0) begin
            timer_nxt = timer - 8'd1;
        end
    end

    // State, timer, early-finish flag and the last payload bit for the trail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= 8'd0;
            fin_seen <= 1'b0;
            last_bit <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            // A finish before DATA means the fifo held a single byte
            if (start_hs) begin
                fin_seen <= 1'b0;
            end else if (fin_rqst && (state inside {S_LPX, S_PREP, S_ZERO, S_SYNC})) begin
                fin_seen <= 1'b1;
            end
            if ((state == S_DATA) && (state_nxt == S_TRAIL)) begin
                last_bit <= inp_data[0];
            end
        end
    end

    // Registered outputs: line image of the current state, busy and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_p        <= 1'b1;
            lp_n        <= 1'b1;
            hs_en       <= 1'b0;
            hs_data     <= 8'h00;
            busy        <= 1'b0;
            err_lp_rqst <= 1'b0;
        end else begin
            busy        <= (state_nxt != S_IDLE);
            err_lp_rqst <= (state == S_IDLE) && start_rqst && mode_lp;
            case (state)
                S_LPX: begin
                    lp_p <= 1'b0; lp_n <= 1'b1; hs_en <= 1'b0; hs_data <= 8'h00;
                end
                S_PREP: begin
                    lp_p <= 1'b0; lp_n <= 1'b0; hs_en <= 1'b0; hs_data <= 8'h00;
                end
                S_ZERO: begin
                    lp_p <= 1'b0; lp_n <= 1'b0; hs_en <= 1'b1; hs_data <= 8'h00;
                end
                S_SYNC: begin
                    lp_p <= 1'b0; lp_n <= 1'b0; hs_en <= 1'b1; hs_data <= SYNC_BYTE;
                end
                S_DATA: begin
                    lp_p <= 1'b0; lp_n <= 1'b0; hs_en <= 1'b1; hs_data <= inp_data;
                end
                S_TRAIL: begin
                    lp_p <= 1'b0; lp_n <= 1'b0; hs_en <= 1'b1; hs_data <= {8{~last_bit}};
                end
                default: begin
                    lp_p <= 1'b1; lp_n <= 1'b1; hs_en <= 1'b0; hs_data <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_lane_hs_sequencer.sv
// Bench for dsi_lane_hs_sequencer. Two instances share one clock:
// lane[0] uses default timing, lane[1] sets every timing parameter to 1.
// Each lane has its own driver script, a reference model that turns a
// payload into the expected line symbols, and a monitor that pops and
// compares whenever the line leaves LP-11.
module tb_dsi_lane_hs_sequencer;

    logic clk;
    int   checks;
    int   errors;
    bit   done [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane_id, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h", name, lane_id, act, exp);
        end
    endtask

    // Line symbol = {lp_p, lp_n, hs_en, hs_data}
    localparam logic [10:0] IDLE_LINE = {3'b110, 8'h00};

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int P_LPX   = (g == 0) ? 2 : 1;
        localparam int P_PREP  = (g == 0) ? 3 : 1;
        localparam int P_ZERO  = (g == 0) ? 6 : 1;
        localparam int P_TRAIL = (g == 0) ? 4 : 1;
        localparam int P_EXIT  = (g == 0) ? 4 : 1;

        logic       rst_n;
        logic       mode_lp;
        logic       start_rqst;
        logic       fin_rqst;
        logic [7:0] inp_data;
        logic       data_rqst;
        logic       hs_en;
        logic [7:0] hs_data;
        logic       lp_p;
        logic       lp_n;
        logic       busy;
        logic       err_lp_rqst;

        dsi_lane_hs_sequencer #(
            .T_LPX(P_LPX), .T_HS_PREPARE(P_PREP), .T_HS_ZERO(P_ZERO),
            .T_HS_TRAIL(P_TRAIL), .T_HS_EXIT(P_EXIT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .mode_lp(mode_lp), .start_rqst(start_rqst),
            .fin_rqst(fin_rqst), .inp_data(inp_data), .data_rqst(data_rqst),
            .hs_en(hs_en), .hs_data(hs_data), .lp_p(lp_p), .lp_n(lp_n),
            .busy(busy), .err_lp_rqst(err_lp_rqst)
        );

        logic [10:0] exp_q [$];
        int          n_q [$];
        logic [7:0]  pay_q [$];
        int          want_gap = -1;
        bit          mon_off;
        int          err_cnt;
        int          dcnt;
        int          lp11_run;
        bit          prev_idle;
        bit          prev_busy;
        logic [10:0] mon_line;
        logic [10:0] mon_exp;

        // Monitor: reset values, line symbols, DATA-cycle count per burst
        always @(negedge clk) begin
            if (!rst_n) begin
                chk("reset_outputs", g,
                    32'({lp_p, lp_n, hs_en, hs_data, data_rqst, busy, err_lp_rqst}),
                    32'(14'b11_0_00000000_1_0_0));
                dcnt = 0; lp11_run = 0; prev_idle = 1'b1; prev_busy = 1'b0;
            end else if (mon_off) begin
                dcnt = 0; lp11_run = 0; prev_idle = 1'b1; prev_busy = busy;
            end else begin
                mon_line = {lp_p, lp_n, hs_en, hs_data};
                if (mon_line != IDLE_LINE) begin
                    if (prev_idle && want_gap >= 0) chk("b2b_gap", g, 32'(lp11_run), 32'(want_gap));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_symbol", g, 32'(mon_line), 32'(IDLE_LINE));
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("line_symbol", g, 32'(mon_line), 32'(mon_exp));
                    end
                    lp11_run = 0; prev_idle = 1'b0;
                end else begin
                    lp11_run++; prev_idle = 1'b1;
                end
                if (busy && data_rqst) dcnt++;
                if (prev_busy && !busy) begin
                    chk("burst_expected", g, 32'(n_q.size() > 0), 32'd1);
                    if (n_q.size() > 0) chk("data_cycles", g, 32'(dcnt), 32'(n_q.pop_front()));
                    dcnt = 0;
                end
                if (err_lp_rqst) err_cnt++;
                prev_busy = busy;
            end
        end

        task automatic wait_idle(input string tag);
            int guard;
            guard = 0;
            while (!(data_rqst && !busy) && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            chk(tag, g, 32'(data_rqst && !busy), 32'd1);
        endtask

        task automatic gen_payload(input int n);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        endtask

        // Reference model: the burst as seen on the line, then drive it
        task automatic run_burst(input bit early);
            logic [7:0] pl [$];
            logic [7:0] last;
            logic [7:0] trail;
            int n, idx, guard;
            pl = pay_q;
            n = pl.size();
            last = pl[n-1];
            trail = {8{~last[0]}};
            for (int i = 0; i < P_LPX; i++)   exp_q.push_back({3'b010, 8'h00});
            for (int i = 0; i < P_PREP; i++)  exp_q.push_back({3'b000, 8'h00});
            for (int i = 0; i < P_ZERO; i++)  exp_q.push_back({3'b001, 8'h00});
            exp_q.push_back({3'b001, 8'h1D});
            for (int i = 0; i < n; i++)       exp_q.push_back({3'b001, pl[i]});
            for (int i = 0; i < P_TRAIL; i++) exp_q.push_back({3'b001, trail});
            n_q.push_back(n);

            wait_idle("start_ready");
            mode_lp = 1'b0; inp_data = pl[0]; start_rqst = 1'b1;
            @(negedge clk);
            start_rqst = 1'b0; fin_rqst = early;
            @(negedge clk);
            fin_rqst = 1'b0;
            idx = 0; guard = 0;
            while (idx < n && guard < 500) begin
                if (busy && data_rqst) begin
                    inp_data = pl[idx];
                    fin_rqst = (idx == n - 1) && !early;
                    idx++;
                end else begin
                    fin_rqst = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
            fin_rqst = 1'b0;
            chk("bytes_consumed", g, 32'(idx), 32'(n));
        endtask

        task automatic rand_burst();
            int n;
            n = $urandom_range(1, 6);
            gen_payload(n);
            run_burst((n == 1) && ($urandom_range(0, 1) == 1));
        endtask

        task automatic drain();
            int guard;
            guard = 0;
            while ((busy || exp_q.size() != 0 || n_q.size() != 0) && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            chk("drained", g, 32'(exp_q.size() + n_q.size()), 32'd0);
        endtask

        task automatic reset_start();
            rst_n = 1'b0; mode_lp = 1'b0; start_rqst = 1'b0; fin_rqst = 1'b0; inp_data = 8'h00;
            mon_off = 1'b0; err_cnt = 0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        endtask

        if (g == 0) begin : script
            initial begin
                int base, k, guard;
                reset_start();
                repeat (10) begin
                    @(negedge clk);
                    chk("idle_lines", g, 32'({lp_p, lp_n, hs_en, data_rqst, busy}), 32'(5'b11010));
                end
                pay_q = '{8'h11, 8'h22, 8'h33};
                run_burst(1'b0);
                pay_q = '{8'hA4};
                run_burst(1'b1);
                drain();

                // LP-mode start is refused; a following fin_rqst must do nothing
                wait_idle("lp_ready");
                base = err_cnt;
                mode_lp = 1'b1; start_rqst = 1'b1;
                @(negedge clk);
                start_rqst = 1'b0; mode_lp = 1'b0;
                repeat (2) @(negedge clk);
                fin_rqst = 1'b1;
                @(negedge clk);
                fin_rqst = 1'b0;
                repeat (8) @(negedge clk);
                chk("err_lp_pulses", g, 32'(err_cnt - base), 32'd1);
                chk("err_lp_not_busy", g, 32'(busy), 32'd0);
                gen_payload(3);
                run_burst(1'b0);
                drain();

                // Reset in the second DATA cycle aborts the burst at once
                wait_idle("abort_ready");
                mon_off = 1'b1;
                inp_data = 8'h5A; start_rqst = 1'b1;
                @(negedge clk);
                start_rqst = 1'b0;
                k = 0; guard = 0;
                while (k < 2 && guard < 100) begin
                    if (busy && data_rqst) k++;
                    if (k < 2) @(negedge clk);
                    guard++;
                end
                chk("abort_reached_data2", g, 32'(k), 32'd2);
                #1 rst_n = 1'b0;
                #1 chk("abort_outputs", g,
                       32'({lp_p, lp_n, hs_en, hs_data, data_rqst, busy, err_lp_rqst}),
                       32'(14'b11_0_00000000_1_0_0));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                mon_off = 1'b0;
                gen_payload(4);
                run_burst(1'b0);

                repeat (12) rand_burst();
                drain();
                done[g] = 1'b1;
            end
        end else begin : script
            initial begin
                reset_start();
                repeat (3) @(negedge clk);
                gen_payload(2);
                run_burst(1'b0);
                // Back-to-back: one EXIT cycle plus the accepting IDLE cycle of LP-11
                want_gap = P_EXIT + 1;
                gen_payload(1);
                run_burst(1'b1);
                gen_payload(1);
                run_burst(1'b0);
                repeat (8) rand_burst();
                drain();
                want_gap = -1;
                repeat (4) rand_burst();
                drain();
                done[g] = 1'b1;
            end
        end
    end

    // End of run: wait for both scripts, then report
    initial begin
        int guard;
        checks = 0;
        errors = 0;
        guard = 0;
        while (!(done[0] && done[1]) && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        chk("scripts_done", -1, 32'(done[0] && done[1]), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
